multi_dataflow_tile_sched: RTL

- Multi-tile job scheduler for the multi_dataflow HWPE. It sits between the register file/slave and the streamer + engine.
- After one start it runs n_tiles back-to-back tiles. For each tile it:
  - computes per-tile base addresses for inStream0 and outStream0;
  - handshakes streamer ready_start, then issues req_start and engine start;
  - waits for the engine output count to reach the per-tile limit;
  - clears the engine counter.
- When all tiles are finished it raises done and evt.

---
 rtl/multi_dataflow_package.sv | 35 +++
 rtl/multi_dataflow_tile_addr.sv | 39 +++
 rtl/multi_dataflow_tile_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/multi_dataflow_package.sv
// Shared types for the multi_dataflow tile scheduler.
//   SCHED_ADDR_W / SCHED_CNT_W : widths the config/flag structs are built from;
//                                the scheduler's ADDR_W / CNT_W default to these
//   sched_state_t  : scheduler FSM states
//   ctrl_sched_t   : job configuration latched on start
//   flags_sched_t  : status flags exported by the scheduler
package multi_dataflow_package;

  localparam int SCHED_ADDR_W = 32;
  localparam int SCHED_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    COMPUTE,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_CNT_W-1:0]  n_tiles;
    logic [SCHED_ADDR_W-1:0] in_base;
    logic [SCHED_ADDR_W-1:0] out_base;
    logic [SCHED_ADDR_W-1:0] in_stride;
    logic [SCHED_ADDR_W-1:0] out_stride;
    logic [SCHED_CNT_W-1:0]  cnt_limit;
  } ctrl_sched_t;

  typedef struct packed {
    logic                   busy;
    logic                   done;
    logic [SCHED_CNT_W-1:0] tile_idx;
  } flags_sched_t;

endpackage

// File: rtl/multi_dataflow_tile_addr.sv
// Per-tile address generator: two offset accumulators plus base adders.
//   clk_i        : clock
//   clear_i      : synchronous clear of both offsets (reset or soft clear)
//   init_i       : zero both offsets at the start of a job
//   step_i       : advance both offsets by their stride (next tile)
//   in/out_base_i, in/out_stride_i : latched job configuration
//   in/out_addr_o: base + offset, wrapping modulo 2^ADDR_W
module multi_dataflow_tile_addr #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              init_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] in_base_i,
  input  logic [ADDR_W-1:0] out_base_i,
  input  logic [ADDR_W-1:0] in_stride_i,
  input  logic [ADDR_W-1:0] out_stride_i,
  output logic [ADDR_W-1:0] in_addr_o,
  output logic [ADDR_W-1:0] out_addr_o
);

  logic [ADDR_W-1:0] in_off, out_off;

  always_ff @(posedge clk_i) begin
    if (clear_i || init_i) begin
      in_off  <= '0;
      out_off <= '0;
    end else if (step_i) begin
      in_off  <= in_off + in_stride_i;
      out_off <= out_off + out_stride_i;
    end
  end

  // Carry out of the top bit is dropped on purpose: addresses wrap silently.
  assign in_addr_o  = in_base_i + in_off;
  assign out_addr_o = out_base_i + out_off;

endmodule

// File: rtl/multi_dataflow_tile_sched.sv
// Multi-tile job scheduler between the slave register file and the
// streamer/engine. One start runs n_tiles back-to-back tiles.
//   clk_i, rst_ni (sync, active low), clear_i (sync soft clear)
//   start_i + config (n_tiles, in/out base, in/out stride, cnt_limit)
//   in/out_ready_start_i : streamer ready flags
//   eng_cnt_i            : engine output counter
//   in/out_req_start_o, eng_start_o : one-cycle tile launch (Mealy)
//   in/out_base_addr_o   : current tile base addresses
//   eng_clear_o          : engine counter clear (IDLE, DONE, tile advance)
//   tile_idx_o, busy_o   : status
//   done_o, evt_o        : registered one-cycle job completion
// ADDR_W / CNT_W must match the package struct widths (the defaults).
module multi_dataflow_tile_sched
  import multi_dataflow_package::*;
#(
  parameter int ADDR_W = SCHED_ADDR_W,
  parameter int CNT_W  = SCHED_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_tiles_i,
  input  logic [ADDR_W-1:0] in_base_i,
  input  logic [ADDR_W-1:0] out_base_i,
  input  logic [ADDR_W-1:0] in_stride_i,
  input  logic [ADDR_W-1:0] out_stride_i,
  input  logic [CNT_W-1:0]  cnt_limit_i,
  input  logic              in_ready_start_i,
  input  logic              out_ready_start_i,
  input  logic [CNT_W-1:0]  eng_cnt_i,
  output logic              in_req_start_o,
  output logic              out_req_start_o,
  output logic [ADDR_W-1:0] in_base_addr_o,
  output logic [ADDR_W-1:0] out_base_addr_o,
  output logic              eng_start_o,
  output logic              eng_clear_o,
  output logic [CNT_W-1:0]  tile_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              evt_o
);

  sched_state_t     state;
  ctrl_sched_t      cfg;
  flags_sched_t     flags;
  logic [CNT_W-1:0] tile_idx;
  logic             done_q;

  logic kill, rdy, last, accept, issue_fire, drain_step;

  assign kill       = !rst_ni || clear_i;
  assign rdy        = in_ready_start_i & out_ready_start_i;
  assign last       = (tile_idx == cfg.n_tiles - CNT_W'(1));
  assign accept     = (state == IDLE) && start_i && (n_tiles_i != '0);
  assign issue_fire = (state == ISSUE) && rdy;
  assign drain_step = (state == DRAIN) && rdy && !last;

  always_ff @(posedge clk_i) begin
    if (kill) begin
      state    <= IDLE;
      cfg      <= '0;
      tile_idx <= '0;
      done_q   <= 1'b0;
    end else begin
      // done lags the DONE state by one cycle, so a clear during DONE still
      // suppresses it.
      done_q <= (state == DONE);
      case (state)
        IDLE: if (start_i) begin
          if (n_tiles_i != '0) begin
            cfg <= '{n_tiles: n_tiles_i, in_base: in_base_i, out_base: out_base_i,
                     in_stride: in_stride_i, out_stride: out_stride_i,
                     cnt_limit: cnt_limit_i};
            tile_idx <= '0;
            state    <= ISSUE;
          end else begin
            // Empty job: report completion without touching the config.
            state <= DONE;
          end
        end
        ISSUE:   if (rdy) state <= COMPUTE;
        COMPUTE: if (eng_cnt_i == cfg.cnt_limit) state <= DRAIN;
        DRAIN: if (rdy) begin
          if (last) begin
            state <= DONE;
          end else begin
            tile_idx <= tile_idx + CNT_W'(1);
            state    <= ISSUE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  multi_dataflow_tile_addr #(.ADDR_W(ADDR_W)) u_addr (
    .clk_i       (clk_i),
    .clear_i     (kill),
    .init_i      (accept),
    .step_i      (drain_step),
    .in_base_i   (cfg.in_base),
    .out_base_i  (cfg.out_base),
    .in_stride_i (cfg.in_stride),
    .out_stride_i(cfg.out_stride),
    .in_addr_o   (in_base_addr_o),
    .out_addr_o  (out_base_addr_o)
  );

  assign flags.busy     = (state != IDLE);
  assign flags.done     = done_q;
  assign flags.tile_idx = tile_idx;

  assign in_req_start_o  = issue_fire;
  assign out_req_start_o = issue_fire;
  assign eng_start_o     = issue_fire;
  assign eng_clear_o     = (state == IDLE) || (state == DONE) || drain_step;
  assign busy_o          = flags.busy;
  assign done_o          = flags.done;
  assign evt_o           = flags.done;
  assign tile_idx_o      = flags.tile_idx;

endmodule
